score_keeper: RTL and testbench
===============================

Name: score_keeper

Overview:
- Tracks the player's climb height as a score and holds the session best score.
- Renders the selected value on the six DE10-Lite seven-segment digits.
- Sits downstream of the game top-level and consumes its frame tick, game_state and move_collision (world-scroll) signals.
- Uses an iterative double-dabble converter so the HEX outputs update a fixed number of cycles after each score change.

Parameters:
- SCORE_DIV, 4: scrolled pixels per score point (>=1).
- SCORE_MAX, 999999: saturation value for score and best.

Ports:
- clk  in  1  system clock (same domain as the doodle and platforms blocks).
- rst  in  1  reset, asynchronous, active-high.
- tick  in  1  one-cycle pulse per game frame (fps_counter wrap).
- game_state  in  2  0=IDLE, 1=PLAY, 2=OVER, 3=reserved (treated as IDLE).
- move_collision  in  1  high while the world scrolls down one pixel per tick.
- show_best  in  1  1 displays best, 0 displays score.
- score  out  20  current score, binary.
- best  out  20  session best, binary.
- hex  out  6x8  active-low segments {dp,g..a}; digit 0 is least significant.
- conv_busy  out  1  converter running.

Behaviour:
- Reset (async assert, sync release): score=0, best=0, prescaler=0, converter IDLE, hex=all 8'hC0 ("0" on each digit), conv_busy=0.
- Game-state tracking: prev_state is registered each cycle.
  - IDLE->PLAY edge: score=0, prescaler=0.
  - PLAY->OVER edge: if score>best then best<=score (one cycle after the edge).
- Scoring runs only when game_state==PLAY, tick=1 and move_collision=1.
  - Prescaler increments on each qualifying tick. When it reaches SCORE_DIV-1 it wraps to 0 and score increments.
  - Score saturates at SCORE_MAX; the prescaler keeps wrapping but score holds.
  - tick without move_collision: no change.
  - Non-PLAY states: score and prescaler frozen.
- Simultaneous IDLE->PLAY edge and qualifying tick: clear wins, so score=0 that cycle.
- Display source: disp = show_best ? best : score. It is registered as last_disp when a conversion starts.
- Converter FSM:
  - IDLE: if disp != last_disp, or a pending request exists, load shift register {24'b0, disp}, set iter=0, go SHIFT, conv_busy=1.
  - SHIFT: each cycle, add 3 to every BCD nibble >=5, then shift left 1, iter++. After 20 shifts go DONE.
  - DONE: hex <= seg(bcd[i]) for all six digits in one cycle, conv_busy=0, go IDLE.
  - Latency: disp change to hex update = 22 cycles (load 1 + 20 shifts + commit 1).
  - A disp change while SHIFT/DONE sets a pending flag. The current conversion finishes and its hex is committed, then the next one starts from IDLE the following cycle. Only one request is pending, and it always converts the latest disp.
- Decimal point segments are always off (bit7=1).
- Reset mid-conversion aborts; hex returns to the reset value.

Optional Feature:
- Macro: SCORE_KEEPER_ZERO_BLANK_EN.
- Defined: in DONE, digits above the most significant non-zero digit are driven 8'hFF (blank). Digit 0 is always shown, so value 0 displays a single "0".
- Undefined: all six digits are always shown with leading zeros.

Decomposition:
- Package score_pkg holds:
  - game_state_t enum (IDLE, PLAY, OVER).
  - SEG_LUT constant: 16 x 8-bit active-low patterns, 0-9 defined, A-F map to 8'hFF.
  - BCD_DIGITS=6, SCORE_W=20.
- Sub-module bcd_converter holds the double-dabble FSM with a start/busy/done handshake. score_keeper owns the counters, best-score logic, pending flag and segment LUT.

Test Plan:
- Reset check: assert rst mid-frame -> score=0, best=0, every hex digit=8'hC0, conv_busy=0 asynchronously.
- Scoring with SCORE_DIV=4: PLAY, 10 ticks with move_collision=1 -> score=2. Then 20 cycles of digit 0 -> 8'hA4 ("2") exactly 22 cycles after score changed.
- Gated tick: PLAY, 5 ticks with move_collision=0, then game_state=OVER plus 8 ticks with move_collision=1 -> score unchanged.
- Best score: OVER with score=37 and best=12 -> best=37. New game with IDLE->PLAY -> score=0. Reach 20, OVER -> best stays 37. show_best=1 -> hex shows 000037 (or blanked "37" with the macro).
- Saturation: force score to 999998 and give 8 qualifying ticks (SCORE_DIV=4) -> score=999999 and holds; hex shows 999999.
- Pending request: change disp from 5 to 6 to 7 within 5 cycles during SHIFT -> hex shows 5, then 7; 6 is never committed; conv_busy falls only after the 7 commit.

Source files
------------

// File: rtl/score_pkg.sv
// Shared definitions for the score_keeper slice.
//   game_state_t : encoding of the game top-level's game_state bus
//                  (value 3 is reserved and behaves like IDLE)
//   BCD_DIGITS   : number of seven-segment digits driven (DE10-Lite HEX0..5)
//   SCORE_W      : width of the binary score / best values
//   SEG_LUT      : active-low {dp,g..a} pattern per BCD nibble; A-F are blank
package score_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } game_state_t;

  localparam int BCD_DIGITS = 6;
  localparam int SCORE_W    = 20;

  localparam logic [7:0] SEG_LUT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF
  };

endpackage

// File: rtl/bcd_converter.sv
// Iterative double-dabble binary-to-BCD converter.
// One conversion takes BIN_W+2 cycles from start: load, BIN_W shifts, done.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   start    : accepted only while idle; captures bin
//   bin      : binary value to convert
//   busy     : high from the load until the done cycle (inclusive)
//   done     : one-cycle pulse while bcd holds the finished result
//   bcd      : packed BCD digits, digit 0 in bcd[3:0]
module bcd_converter #(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [DIGITS*4-1:0]   bcd
);

  localparam int SR_W   = DIGITS * 4 + BIN_W;
  localparam int ITER_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    C_IDLE,
    C_SHIFT,
    C_DONE
  } cvt_state_t;

  cvt_state_t        state, state_nx;
  logic [SR_W-1:0]   sr, sr_nx, sr_adj;
  logic [ITER_W-1:0] iter, iter_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= C_IDLE;
      sr    <= '0;
      iter  <= '0;
    end else begin
      state <= state_nx;
      sr    <= sr_nx;
      iter  <= iter_nx;
    end
  end

  always_comb begin
    state_nx = state;
    sr_nx    = sr;
    iter_nx  = iter;
    sr_adj   = sr;
    case (state)
      C_IDLE: begin
        if (start) begin
          sr_nx    = {{(DIGITS*4){1'b0}}, bin};
          iter_nx  = '0;
          state_nx = C_SHIFT;
        end
      end
      C_SHIFT: begin
        // Adjust every BCD nibble before the shift so it carries correctly.
        for (int unsigned i = 0; i < DIGITS; i++) begin
          if (sr_adj[BIN_W + 4*i +: 4] >= 4'd5)
            sr_adj[BIN_W + 4*i +: 4] = sr_adj[BIN_W + 4*i +: 4] + 4'd3;
        end
        sr_nx   = sr_adj << 1;
        iter_nx = iter + 1'b1;
        if (iter == ITER_W'(BIN_W - 1))
          state_nx = C_DONE;
      end
      C_DONE: begin
        state_nx = C_IDLE;
      end
      default: begin
        state_nx = C_IDLE;
      end
    endcase
  end

  assign busy = (state != C_IDLE);
  assign done = (state == C_DONE);
  assign bcd  = sr[SR_W-1 -: DIGITS*4];

endmodule

// File: rtl/score_keeper.sv
// Climb-height score keeper with session best and six-digit HEX display.
// Optional build macro: SCORE_KEEPER_ZERO_BLANK_EN blanks leading zero digits.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   tick            : one-cycle pulse per game frame
//   game_state      : 0=IDLE 1=PLAY 2=OVER 3=reserved (acts as IDLE)
//   move_collision  : world is scrolling this frame
//   show_best       : display best (1) or current score (0)
//   score, best     : binary current and best score
//   hex             : active-low segments {dp,g..a}, hex[0] least significant
//   conv_busy       : a conversion is running or queued
module score_keeper
  import score_pkg::*;
#(
  parameter int SCORE_DIV = 4,
  parameter int SCORE_MAX = 999999
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tick,
  input  logic [1:0]                    game_state,
  input  logic                          move_collision,
  input  logic                          show_best,
  output logic [SCORE_W-1:0]            score,
  output logic [SCORE_W-1:0]            best,
  output logic [BCD_DIGITS-1:0][7:0]    hex,
  output logic                          conv_busy
);

  localparam int PW = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;

  logic [1:0]          prev_state;
  logic [PW-1:0]       presc;
  logic [SCORE_W-1:0]  score_q, best_q;
  logic                is_play, prev_idle, start_game, end_game, qual;

  assign is_play    = (game_state == PLAY);
  // Reserved encoding counts as IDLE, so anything not PLAY/OVER is idle.
  assign prev_idle  = (prev_state != PLAY) && (prev_state != OVER);
  assign start_game = prev_idle && is_play;
  assign end_game   = (prev_state == PLAY) && (game_state == OVER);
  assign qual       = is_play && tick && move_collision;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_state <= IDLE;
      presc      <= '0;
      score_q    <= '0;
      best_q     <= '0;
    end else begin
      prev_state <= game_state;
      if (start_game) begin
        score_q <= '0;
        presc   <= '0;
      end else if (qual) begin
        if (presc == PW'(SCORE_DIV - 1)) begin
          presc <= '0;
          if (score_q < SCORE_W'(SCORE_MAX))
            score_q <= score_q + 1'b1;
        end else begin
          presc <= presc + 1'b1;
        end
      end
      if (end_game && (score_q > best_q))
        best_q <= score_q;
    end
  end

  assign score = score_q;
  assign best  = best_q;

  logic [SCORE_W-1:0]               disp, last_disp;
  logic                             pending, cvt_start, cvt_busy, cvt_done;
  logic [BCD_DIGITS*4-1:0]          bcd;
  logic [BCD_DIGITS-1:0][7:0]       hex_q, seg_nx;

  assign disp      = show_best ? best_q : score_q;
  assign cvt_start = !cvt_busy && ((disp != last_disp) || pending);

  bcd_converter #(
    .BIN_W  (SCORE_W),
    .DIGITS (BCD_DIGITS)
  ) u_cvt (
    .clk   (clk),
    .rst   (rst),
    .start (cvt_start),
    .bin   (disp),
    .busy  (cvt_busy),
    .done  (cvt_done),
    .bcd   (bcd)
  );

  always_comb begin
    seg_nx = '1;
    for (int unsigned i = 0; i < BCD_DIGITS; i++)
      seg_nx[i] = SEG_LUT[bcd[4*i +: 4]];
`ifdef SCORE_KEEPER_ZERO_BLANK_EN
    // Walk down from the top digit, blanking until the first non-zero one.
    begin
      logic blank;
      blank = 1'b1;
      for (int unsigned k = 0; k < BCD_DIGITS - 1; k++) begin
        if (bcd[4*(BCD_DIGITS-1-k) +: 4] != 4'd0)
          blank = 1'b0;
        if (blank)
          seg_nx[BCD_DIGITS-1-k] = 8'hFF;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_disp <= '0;
      pending   <= 1'b0;
      hex_q     <= {BCD_DIGITS{8'hC0}};
    end else begin
      if (cvt_start) begin
        last_disp <= disp;
        pending   <= 1'b0;
      end else if (cvt_busy && (disp != last_disp)) begin
        pending   <= 1'b1;
      end
      if (cvt_done)
        hex_q <= seg_nx;
    end
  end

  assign hex = hex_q;
  // Queued work keeps busy high across the idle cycle between conversions.
  assign conv_busy = cvt_busy | pending;

endmodule

// File: tb/tb_score_keeper.sv
module tb_score_keeper;

  localparam int DIV = 4;
  localparam int MAX = 999999;

  logic             clk = 1'b0;
  logic             rst;
  logic             tick;
  logic [1:0]       game_state;
  logic             move_collision;
  logic             show_best;
  logic [19:0]      score, best;
  logic [5:0][7:0]  hex;
  logic             conv_busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  score_keeper #(
    .SCORE_DIV (DIV),
    .SCORE_MAX (MAX)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .tick           (tick),
    .game_state     (game_state),
    .move_collision (move_collision),
    .show_best      (show_best),
    .score          (score),
    .best           (best),
    .hex            (hex),
    .conv_busy      (conv_busy)
  );

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: score is total qualifying ticks / DIV, clipped at MAX.
  int   m_ticks, m_best, m_score;
  logic [1:0] m_prev;
  logic force_req = 1'b0;

  always_comb m_score = (m_ticks / DIV > MAX) ? MAX : m_ticks / DIV;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ticks <= 0;
      m_best  <= 0;
      m_prev  <= 2'd0;
    end else begin
      m_prev <= game_state;
      if (force_req)
        m_ticks <= 999998 * DIV + (m_ticks % DIV);
      else if ((m_prev == 2'd0 || m_prev == 2'd3) && game_state == 2'd1)
        m_ticks <= 0;
      else if (game_state == 2'd1 && tick && move_collision)
        m_ticks <= m_ticks + 1;
      if (m_prev == 2'd1 && game_state == 2'd2 && m_score > m_best)
        m_best <= m_score;
    end
  end

  function automatic logic [7:0] seg_of(input int d);
    case (d)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [47:0] exp_hex(input int v);
    logic [47:0] h;
    int top, t, p;
    top = 0;
    t = v;
    while (t >= 10) begin
      t = t / 10;
      top++;
    end
    p = 1;
    for (int i = 0; i < 6; i++) begin
      h[i*8 +: 8] = seg_of((v / p) % 10);
`ifdef SCORE_KEEPER_ZERO_BLANK_EN
      if (i > top) h[i*8 +: 8] = 8'hFF;
`endif
      p = p * 10;
    end
    return h;
  endfunction

  // Continuous score/best comparison against the model.
  logic chk_on = 1'b0;
  always begin
    @(negedge clk);
    #1;
    if (chk_on && !rst) begin
      check("score", score, m_score);
      check("best", best, m_best);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic qual_ticks(input int n);
    repeat (n) begin
      tick = 1'b1;
      move_collision = 1'b1;
      @(negedge clk);
    end
    tick = 1'b0;
  endtask

  task automatic new_game();
    game_state = 2'd0;
    @(negedge clk);
    game_state = 2'd1;
    @(negedge clk);
  endtask

  task automatic end_game();
    game_state = 2'd2;
    cycles(2);
  endtask

  task automatic settle_check(input string tag);
    tick = 1'b0;
    cycles(50);
    check({tag, "_busy"}, conv_busy, 0);
    check({tag, "_hex"}, hex, exp_hex(show_best ? m_best : m_score));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_chg, t_hex, nt, t5, t7, bad6, busy_gap, b7;
    logic [47:0] h5, h6, h7;

    rst = 1'b1;
    tick = 1'b0;
    game_state = 2'd0;
    move_collision = 1'b0;
    show_best = 1'b0;
    cycles(3);
    rst = 1'b0;
    @(negedge clk);

    check("rst_score", score, 0);
    check("rst_best", best, 0);
    check("rst_hex", hex, {6{8'hC0}});
    check("rst_busy", conv_busy, 0);
    chk_on = 1'b1;

    // Scoring and display latency: ticks spaced 8 cycles apart.
    new_game();
    t_chg = -1;
    t_hex = -1;
    nt = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (score == 20'd2 && t_chg < 0) t_chg = c;
      if (t_chg >= 0 && hex[0] == 8'hA4 && t_hex < 0) t_hex = c;
      tick = (c % 8 == 0) && (nt < 10);
      move_collision = 1'b1;
      if (tick) nt++;
    end
    tick = 1'b0;
    check("score_10ticks", score, 2);
    check("latency_found", (t_chg >= 0 && t_hex >= 0), 1);
    check("latency_22", t_hex - t_chg, 22);

    // Gated ticks.
    move_collision = 1'b0;
    repeat (5) begin
      tick = 1'b1;
      @(negedge clk);
    end
    tick = 1'b0;
    check("gated_nomc", score, 2);
    end_game();
    qual_ticks(8);
    check("gated_over", score, 2);

    // Best score tracking.
    new_game();
    qual_ticks(12 * DIV);
    end_game();
    check("best_12", best, 12);
    new_game();
    qual_ticks(37 * DIV);
    end_game();
    check("best_37", best, 37);
    new_game();
    cycles(1);
    check("newgame_clear", score, 0);
    qual_ticks(20 * DIV);
    end_game();
    check("best_keep37", best, 37);
    show_best = 1'b1;
    settle_check("show_best37");
    check("best37_digits", hex, exp_hex(37));

    // Saturation.
    show_best = 1'b0;
    chk_on = 1'b0;
    @(negedge clk);
    force dut.score_q = 20'd999998;
    force_req = 1'b1;
    @(negedge clk);
    release dut.score_q;
    force_req = 1'b0;
    chk_on = 1'b1;
    game_state = 2'd1;
    @(negedge clk);
    qual_ticks(8);
    check("sat_score", score, MAX);
    qual_ticks(4);
    check("sat_hold", score, MAX);
    settle_check("sat");
    check("sat_digits", hex, exp_hex(999999));
    end_game();

    // Reset in the middle of a conversion.
    show_best = 1'b1;
    cycles(5);
    #3;
    rst = 1'b1;
    #1;
    check("rst_mid_score", score, 0);
    check("rst_mid_best", best, 0);
    check("rst_mid_hex", hex, {6{8'hC0}});
    check("rst_mid_busy", conv_busy, 0);
    @(negedge clk);
    rst = 1'b0;
    show_best = 1'b0;
    game_state = 2'd0;
    cycles(2);

    // Pending request: display 6, then 5 -> 6 -> 7 within a conversion.
    new_game();
    qual_ticks(5 * DIV);
    end_game();
    new_game();
    qual_ticks(6 * DIV + 3);
    settle_check("pend_pre6");
    h5 = exp_hex(5);
    h6 = exp_hex(6);
    h7 = exp_hex(7);
    show_best = 1'b1;
    cycles(2);
    show_best = 1'b0;
    @(negedge clk);
    tick = 1'b1;
    move_collision = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    t5 = -1;
    t7 = -1;
    bad6 = 0;
    busy_gap = 0;
    b7 = 1;
    for (int c = 0; c < 100 && t7 < 0; c++) begin
      @(negedge clk);
      if (t5 < 0 && hex == h5) t5 = c;
      if (t5 >= 0 && hex == h6) bad6++;
      if (hex == h7) begin
        t7 = c;
        b7 = conv_busy;
      end else if (!conv_busy) begin
        busy_gap++;
      end
    end
    check("pend_5_then_7", (t5 >= 0 && t7 > t5), 1);
    check("pend_no6", bad6, 0);
    check("pend_busy_held", busy_gap, 0);
    check("pend_busy_end", b7, 0);
    check("pend_score7", score, 7);

    // Randomized play.
    for (int blk = 0; blk < 12; blk++) begin
      for (int c = 0; c < 250; c++) begin
        if ($urandom_range(19) == 0) game_state = 2'($urandom_range(3));
        tick = ($urandom_range(1) == 1);
        move_collision = ($urandom_range(3) != 0);
        if ($urandom_range(39) == 0) show_best = ~show_best;
        @(negedge clk);
      end
      settle_check("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
